sdram_request_queue: RTL and testbench

// - Buffers read/write commands from user logic in an in-order FIFO.
// - Issues them one at a time to sdram_controller over its level req / ack handshake.
// - Returns read data with a one-cycle valid pulse.
// - Sits directly upstream of sdram_controller and replaces the key-driven request FSM in bench tops.

---
 rtl/sdram_pkg.sv | 20 ++
 rtl/sdram_cmd_fifo.sv | 57 +++++
 rtl/sdram_request_queue.sv | 147 ++++++++++++++
 tb/tb_sdram_request_queue.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM request queue: command record and issue FSM states.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 22;
  localparam int SDRAM_DATA_W = 128;

  typedef struct packed {
    logic                    write;
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [SDRAM_DATA_W-1:0] data;
  } sdram_cmd_t;

  typedef enum logic [1:0] {
    Q_IDLE,
    Q_WR,
    Q_RD,
    Q_DONE
  } q_state_t;

endpackage

// File: rtl/sdram_cmd_fifo.sv
// Synchronous in-order FIFO of SDRAM commands. Push while full and pop while
// empty are dropped; a simultaneous push and pop leave the level unchanged.
module sdram_cmd_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     iclk,
  input  logic                     ireset,
  input  logic                     ipush,
  input  logic                     ipop,
  input  sdram_cmd_t               ipush_cmd,
  output sdram_cmd_t               ohead,
  output logic                     ofull,
  output logic                     oempty,
  output logic [$clog2(DEPTH):0]   olevel
);

  localparam int PTR_W = $clog2(DEPTH);

  sdram_cmd_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level_q;
  logic             push_en;
  logic             pop_en;

  assign ofull   = (level_q == (PTR_W+1)'(DEPTH));
  assign oempty  = (level_q == '0);
  assign olevel  = level_q;
  assign push_en = ipush & ~ofull;
  assign pop_en  = ipop & ~oempty;
  assign ohead   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Command storage is data only and needs no reset.
  always_ff @(posedge iclk) begin
    if (push_en) mem[wr_ptr] <= ipush_cmd;
  end

endmodule

// File: rtl/sdram_request_queue.sv
// Buffers user read/write commands and issues them one at a time to
// sdram_controller over a level req/ack handshake, with a per-command watchdog.
module sdram_request_queue
  import sdram_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = SDRAM_ADDR_W,
  parameter int DATA_W  = SDRAM_DATA_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                    iclk,
  input  logic                    ireset,
  input  logic                    icmd_valid,
  input  logic                    icmd_write,
  input  logic [ADDR_W-1:0]       icmd_address,
  input  logic [DATA_W-1:0]       icmd_data,
  output logic                    ocmd_ready,
  output logic                    orsp_valid,
  output logic [DATA_W-1:0]       orsp_data,
  output logic                    oerror,
  output logic [$clog2(DEPTH):0]  olevel,
  output logic                    owrite_req,
  output logic [ADDR_W-1:0]       owrite_address,
  output logic [DATA_W-1:0]       owrite_data,
  input  logic                    iwrite_ack,
  output logic                    oread_req,
  output logic [ADDR_W-1:0]       oread_address,
  input  logic [DATA_W-1:0]       iread_data,
  input  logic                    iread_ack
);

  localparam int WD_W = $clog2(TIMEOUT);

  q_state_t         state_q;
  q_state_t         state_d;
  sdram_cmd_t       push_cmd;
  sdram_cmd_t       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             rd_done;
  logic             timeout;
  logic             wd_expired;
  logic [WD_W-1:0]  wd_q;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;

  assign push_cmd.write = icmd_write;
  assign push_cmd.addr  = icmd_address;
  assign push_cmd.data  = icmd_data;
  assign ocmd_ready     = ~fifo_full;

  sdram_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .iclk      (iclk),
    .ireset    (ireset),
    .ipush     (icmd_valid & ocmd_ready),
    .ipop      (pop),
    .ipush_cmd (push_cmd),
    .ohead     (head),
    .ofull     (fifo_full),
    .oempty    (fifo_empty),
    .olevel    (olevel)
  );

  assign wd_expired     = (wd_q == WD_W'(TIMEOUT - 1));
  assign owrite_address = issue_addr;
  assign owrite_data    = issue_data;
  assign oread_address  = issue_addr;

  // Issue FSM state register.
  always_ff @(posedge iclk) begin
    if (ireset) state_q <= Q_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode; requests are a pure function of state.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    owrite_req = 1'b0;
    oread_req  = 1'b0;
    rd_done    = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      Q_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = head.write ? Q_WR : Q_RD;
        end
      end
      Q_WR: begin
        owrite_req = 1'b1;
        if (iwrite_ack) begin
          state_d = Q_DONE;
        end else if (wd_expired) begin
          timeout = 1'b1;
          state_d = Q_DONE;
        end
      end
      Q_RD: begin
        oread_req = 1'b1;
        if (iread_ack) begin
          rd_done = 1'b1;
          state_d = Q_DONE;
        end else if (wd_expired) begin
          timeout = 1'b1;
          state_d = Q_DONE;
        end
      end
      Q_DONE: begin
        state_d = Q_IDLE;
      end
      default: begin
        state_d = Q_IDLE;
      end
    endcase
  end

  // Issue register: holds the popped command stable for the whole WR/RD state.
  always_ff @(posedge iclk) begin
    if (pop) begin
      issue_addr <= head.addr;
      issue_data <= head.data;
    end
  end

  // Watchdog counts cycles spent in WR/RD and restarts from zero on each entry.
  always_ff @(posedge iclk) begin
    if (ireset)                                  wd_q <= '0;
    else if (state_q == Q_WR || state_q == Q_RD) wd_q <= wd_q + 1'b1;
    else                                         wd_q <= '0;
  end

  // Response and error pulses land in the DONE cycle; read data is held.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      orsp_valid <= 1'b0;
      oerror     <= 1'b0;
      orsp_data  <= '0;
    end else begin
      orsp_valid <= rd_done;
      oerror     <= timeout;
      if (rd_done) orsp_data <= iread_data;
    end
  end

endmodule

// File: tb/tb_sdram_request_queue.sv
// Bench for sdram_request_queue with a behavioural controller model and a
// read-response scoreboard.
module tb_sdram_request_queue;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 22;
  localparam int DATA_W  = 128;
  localparam int TIMEOUT = 16;

  logic              iclk = 1'b0;
  logic              ireset = 1'b1;
  logic              icmd_valid = 1'b0;
  logic              icmd_write = 1'b0;
  logic [ADDR_W-1:0] icmd_address = '0;
  logic [DATA_W-1:0] icmd_data = '0;
  logic              ocmd_ready;
  logic              orsp_valid;
  logic [DATA_W-1:0] orsp_data;
  logic              oerror;
  logic [$clog2(DEPTH):0] olevel;
  logic              owrite_req;
  logic [ADDR_W-1:0] owrite_address;
  logic [DATA_W-1:0] owrite_data;
  logic              iwrite_ack = 1'b0;
  logic              oread_req;
  logic [ADDR_W-1:0] oread_address;
  logic [DATA_W-1:0] iread_data = '0;
  logic              iread_ack = 1'b0;

  always #5 iclk = ~iclk;

  sdram_request_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .iclk(iclk), .ireset(ireset),
    .icmd_valid(icmd_valid), .icmd_write(icmd_write),
    .icmd_address(icmd_address), .icmd_data(icmd_data),
    .ocmd_ready(ocmd_ready), .orsp_valid(orsp_valid), .orsp_data(orsp_data),
    .oerror(oerror), .olevel(olevel),
    .owrite_req(owrite_req), .owrite_address(owrite_address),
    .owrite_data(owrite_data), .iwrite_ack(iwrite_ack),
    .oread_req(oread_req), .oread_address(oread_address),
    .iread_data(iread_data), .iread_ack(iread_ack)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] shadow [int];
  logic [DATA_W-1:0] mem [int];

  bit stall = 1'b0;
  int ack_delay = 0;
  int ack_hold = 1;
  int req_starts = 0;
  int rsp_count = 0;
  int err_count = 0;

  // Controller model: acks after ack_delay cycles, holds ack for ack_hold cycles.
  task automatic controller_model();
    int ack_left = 0;
    int wait_cnt = 0;
    forever begin
      @(negedge iclk);
      if (ireset) begin
        iwrite_ack = 1'b0; iread_ack = 1'b0; ack_left = 0; wait_cnt = 0;
      end else if (ack_left > 0) begin
        ack_left--;
        if (ack_left == 0) begin iwrite_ack = 1'b0; iread_ack = 1'b0; end
      end else if ((owrite_req || oread_req) && !stall) begin
        if (wait_cnt < ack_delay) wait_cnt++;
        else begin
          wait_cnt = 0;
          ack_left = ack_hold;
          if (owrite_req) begin
            mem[int'(owrite_address)] = owrite_data;
            iwrite_ack = 1'b1;
          end else begin
            iread_data = mem.exists(int'(oread_address)) ? mem[int'(oread_address)] : '0;
            iread_ack = 1'b1;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  endtask

  // Output monitor: scoreboard compare on orsp_valid, request spacing, exclusivity.
  task automatic monitor();
    bit prev_req = 1'b0;
    bit seen_req = 1'b0;
    int low_run = 0;
    bit cur_req;
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge iclk);
      if (ireset) begin
        prev_req = 1'b0; seen_req = 1'b0; low_run = 0;
      end else begin
        if (owrite_req && oread_req) begin
          errors++;
          $display("FAIL req_exclusive: both owrite_req and oread_req high at %0t", $time);
        end
        if (orsp_valid) begin
          checks++;
          rsp_count++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: orsp_data=%h with no read outstanding", orsp_data);
          end else begin
            e = exp_q.pop_front();
            if (orsp_data !== e) begin
              errors++;
              $display("FAIL rsp_data: got %h expected %h", orsp_data, e);
            end
          end
        end
        if (oerror) err_count++;
        cur_req = owrite_req | oread_req;
        if (cur_req && !prev_req) begin
          req_starts++;
          if (seen_req) begin
            checks++;
            if (low_run < 2) begin
              errors++;
              $display("FAIL req_gap: %0d idle cycles between requests, need at least 2", low_run);
            end
          end
          seen_req = 1'b1;
        end
        low_run  = cur_req ? 0 : low_run + 1;
        prev_req = cur_req;
      end
    end
  endtask

  task automatic push_cmd(input bit w, input int a, input logic [DATA_W-1:0] d, input bit exp_acc);
    icmd_valid   = 1'b1;
    icmd_write   = w;
    icmd_address = ADDR_W'(a);
    icmd_data    = d;
    checks++;
    if (ocmd_ready !== exp_acc) begin
      errors++;
      $display("FAIL push_ready addr=%0d: ocmd_ready=%b expected %b", a, ocmd_ready, exp_acc);
    end
    if (exp_acc) begin
      if (w) shadow[a] = d;
      else   exp_q.push_back(shadow.exists(a) ? shadow[a] : '0);
    end
    @(posedge iclk); #1;
    icmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    int idle_run = 0;
    while (idle_run < 3 && n < budget) begin
      @(posedge iclk); #1;
      n++;
      if (olevel == 0 && !owrite_req && !oread_req) idle_run++;
      else idle_run = 0;
    end
    checks++;
    if (idle_run < 3) begin
      errors++;
      $display("FAIL drain_%s: queue still busy after %0d cycles, olevel=%0d", tag, n, olevel);
    end
  endtask

  task automatic test_reset();
    ireset = 1'b1;
    repeat (2) @(posedge iclk);
    #1;
    checks += 6;
    if (olevel !== 0)     begin errors++; $display("FAIL reset_level: %0d expected 0", olevel); end
    if (ocmd_ready !== 1) begin errors++; $display("FAIL reset_ready: %b expected 1", ocmd_ready); end
    if (owrite_req !== 0 || oread_req !== 0) begin
      errors++; $display("FAIL reset_req: wr=%b rd=%b expected 0 0", owrite_req, oread_req);
    end
    if (orsp_valid !== 0) begin errors++; $display("FAIL reset_rsp_valid: %b expected 0", orsp_valid); end
    if (oerror !== 0)     begin errors++; $display("FAIL reset_error: %b expected 0", oerror); end
    if (orsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: %h expected 0", orsp_data); end
    ireset = 1'b0;
    @(posedge iclk); #1;
  endtask

  task automatic test_write_read();
    int rsp0 = rsp_count;
    ack_delay = 2; ack_hold = 1; stall = 1'b0;
    push_cmd(1'b1, 3, 128'hA5, 1'b1);
    checks++;
    if (owrite_req !== 0) begin errors++; $display("FAIL issue_early: owrite_req=%b expected 0", owrite_req); end
    @(posedge iclk); #1;
    checks += 3;
    if (owrite_req !== 1 || oread_req !== 0) begin
      errors++; $display("FAIL issue_latency: wr=%b rd=%b expected 1 0", owrite_req, oread_req);
    end
    if (owrite_address !== ADDR_W'(3)) begin
      errors++; $display("FAIL wr_addr: %0d expected 3", owrite_address);
    end
    if (owrite_data !== 128'hA5) begin
      errors++; $display("FAIL wr_data: %h expected a5", owrite_data);
    end
    @(posedge iclk); #1;
    checks++;
    if (owrite_req !== 1) begin errors++; $display("FAIL wr_hold: owrite_req=%b expected 1 before ack", owrite_req); end
    push_cmd(1'b0, 3, '0, 1'b1);
    wait_idle(100, "wr_rd");
    checks++;
    if (rsp_count - rsp0 !== 1) begin
      errors++; $display("FAIL wr_rd_rsp_count: %0d expected 1", rsp_count - rsp0);
    end
  endtask

  task automatic test_full();
    ack_delay = 0; ack_hold = 1; stall = 1'b1;
    push_cmd(1'b1, 10, 128'h1010, 1'b1);
    push_cmd(1'b1, 11, 128'h1111, 1'b1);
    push_cmd(1'b0, 10, '0, 1'b1);
    push_cmd(1'b0, 11, '0, 1'b1);
    push_cmd(1'b1, 12, 128'h1212, 1'b1);
    checks += 2;
    if (olevel !== 4) begin errors++; $display("FAIL full_level: %0d expected 4", olevel); end
    if (ocmd_ready !== 0) begin errors++; $display("FAIL full_ready: %b expected 0", ocmd_ready); end
    push_cmd(1'b0, 12, '0, 1'b0);
    checks++;
    if (olevel !== 4) begin errors++; $display("FAIL full_ignore: olevel=%0d expected 4", olevel); end
    stall = 1'b0;
    push_cmd(1'b0, 12, '0, 1'b0);
    wait_idle(200, "full");
    push_cmd(1'b0, 12, '0, 1'b1);
    wait_idle(100, "full_tail");
  endtask

  task automatic test_ack_hold();
    int s0 = req_starts;
    int r0 = rsp_count;
    ack_delay = 1; ack_hold = 3; stall = 1'b0;
    push_cmd(1'b1, 30, 128'h3030, 1'b1);
    push_cmd(1'b0, 30, '0, 1'b1);
    push_cmd(1'b1, 31, 128'h3131, 1'b1);
    push_cmd(1'b0, 31, '0, 1'b1);
    wait_idle(200, "ack_hold");
    checks += 2;
    if (req_starts - s0 !== 4) begin
      errors++; $display("FAIL hold_req_count: %0d expected 4", req_starts - s0);
    end
    if (rsp_count - r0 !== 2) begin
      errors++; $display("FAIL hold_rsp_count: %0d expected 2", rsp_count - r0);
    end
    ack_hold = 1;
  endtask

  task automatic test_timeout();
    int e0 = err_count;
    int r0 = rsp_count;
    int hi_cnt;
    int n = 0;
    bit dropped = 1'b0;
    ack_delay = 0; ack_hold = 1; stall = 1'b1;
    push_cmd(1'b1, 50, 128'h5050, 1'b1);
    push_cmd(1'b0, 3, '0, 1'b1);
    hi_cnt = owrite_req ? 1 : 0;
    while (!dropped && n < 40) begin
      @(posedge iclk); #1;
      n++;
      if (owrite_req) hi_cnt++;
      else if (hi_cnt > 0) dropped = 1'b1;
    end
    stall = 1'b0;
    checks += 2;
    if (!dropped) begin
      errors++; $display("FAIL timeout_drop: owrite_req still high after %0d cycles", n);
    end else if (oerror !== 1) begin
      errors++; $display("FAIL timeout_error: oerror=%b expected 1", oerror);
    end
    if (hi_cnt !== TIMEOUT) begin
      errors++; $display("FAIL timeout_len: req high %0d cycles expected %0d", hi_cnt, TIMEOUT);
    end
    wait_idle(100, "timeout");
    checks += 2;
    if (err_count - e0 !== 1) begin
      errors++; $display("FAIL timeout_pulses: %0d expected 1", err_count - e0);
    end
    if (rsp_count - r0 !== 1) begin
      errors++; $display("FAIL timeout_next_rsp: %0d expected 1", rsp_count - r0);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    stall = 1'b1;
    push_cmd(1'b0, 3, '0, 1'b1);
    push_cmd(1'b0, 3, '0, 1'b1);
    push_cmd(1'b0, 3, '0, 1'b1);
    checks += 2;
    if (oread_req !== 1) begin errors++; $display("FAIL mid_rd_active: oread_req=%b expected 1", oread_req); end
    if (olevel !== 2) begin errors++; $display("FAIL mid_level: %0d expected 2", olevel); end
    ireset = 1'b1;
    @(posedge iclk); #1;
    exp_q.delete();
    checks += 3;
    if (oread_req !== 0 || owrite_req !== 0) begin
      errors++; $display("FAIL mid_req: wr=%b rd=%b expected 0 0", owrite_req, oread_req);
    end
    if (olevel !== 0) begin errors++; $display("FAIL mid_flush: olevel=%0d expected 0", olevel); end
    if (orsp_valid !== 0) begin errors++; $display("FAIL mid_rsp_valid: %b expected 0", orsp_valid); end
    ireset = 1'b0;
    stall = 1'b0;
    r0 = rsp_count;
    repeat (30) @(posedge iclk);
    #1;
    checks++;
    if (rsp_count !== r0) begin
      errors++; $display("FAIL mid_stale: %0d responses after reset expected 0", rsp_count - r0);
    end
  endtask

  task automatic test_push_pop();
    int n = 0;
    ack_delay = 0; ack_hold = 1; stall = 1'b1;
    push_cmd(1'b1, 20, 128'h2020, 1'b1);
    push_cmd(1'b0, 20, '0, 1'b1);
    push_cmd(1'b1, 21, 128'h2121, 1'b1);
    checks++;
    if (olevel !== 2) begin errors++; $display("FAIL pp_setup_level: %0d expected 2", olevel); end
    stall = 1'b0;
    while (owrite_req && n < 20) begin
      @(posedge iclk); #1;
      n++;
    end
    @(posedge iclk); #1;
    checks++;
    if (olevel !== 2) begin errors++; $display("FAIL pp_idle_level: %0d expected 2", olevel); end
    push_cmd(1'b0, 21, '0, 1'b1);
    checks++;
    if (olevel !== 2) begin errors++; $display("FAIL pp_level: %0d expected 2 after push+pop", olevel); end
    wait_idle(100, "push_pop");
  endtask

  initial begin
    fork
      controller_model();
      monitor();
    join_none
    test_reset();
    test_write_read();
    test_full();
    test_ack_hold();
    test_timeout();
    test_reset_mid();
    test_push_pop();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_leftover: %0d reads never answered", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
